// File: rtl/text_pkg.sv
// Shared geometry, control codes and sweep FSM states for the 7x20 character buffer.
package text_pkg;

    localparam int ROWS   = 7;
    localparam int COLS   = 20;
    localparam int CELLS  = 140;
    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] SPACE    = 8'h20;
    localparam logic [CHAR_W-1:0] LF       = 8'h0A;
    localparam logic [CHAR_W-1:0] CR       = 8'h0D;
    localparam logic [CHAR_W-1:0] BS       = 8'h08;
    localparam logic [CHAR_W-1:0] FF       = 8'h0C;
    localparam logic [CHAR_W-1:0] PRINT_LO = 8'h20;
    localparam logic [CHAR_W-1:0] PRINT_HI = 8'h7E;

    localparam logic [3:0] LAST_ROW        = 4'd6;
    localparam logic [5:0] LAST_COL        = 6'd19;
    localparam logic [7:0] LAST_CELL       = 8'd139;
    localparam logic [7:0] SCROLL_COPY_END = 8'd120;
    localparam logic [7:0] ROW_STRIDE      = 8'd20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } state_e;

    function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [5:0] col);
        return ({4'b0, row} * ROW_STRIDE) + {2'b0, col};
    endfunction

endpackage

// File: rtl/text_buffer.sv
// Character buffer with cursor, control-code handling and clear/scroll sweeps
// that rewrite one cell per cycle while input is stalled.
module text_buffer
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        rin,
    input  logic [5:0]        cin,
    output logic [CHAR_W-1:0] charout,
    output logic [3:0]        cur_row,
    output logic [5:0]        cur_col,
    output logic              busy
);

    logic [CHAR_W-1:0] mem_q [CELLS];

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;

    logic              we;
    logic [7:0]        waddr;
    logic [CHAR_W-1:0] wdata;
    logic              newline;
    logic              inRange;
    logic [7:0]        readIdx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Contents are left undefined by reset; the CLEAR sweep entered on reset defines them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = '0;
        wdata   = SPACE;
        newline = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= PRINT_LO && in_data <= PRINT_HI) begin
                        we    = 1'b1;
                        waddr = cell_index(row_q, col_q);
                        wdata = in_data;
                        if (col_q == LAST_COL) begin
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else if (in_data == LF || in_data == CR) begin
                        newline = 1'b1;
                    end else if (in_data == BS) begin
                        if (row_q != '0 || col_q != '0) begin
                            if (col_q == '0) begin
                                row_d = row_q - 4'd1;
                                col_d = LAST_COL;
                            end else begin
                                col_d = col_q - 6'd1;
                            end
                            we    = 1'b1;
                            waddr = cell_index(row_d, col_d);
                            wdata = SPACE;
                        end
                    end else if (in_data == FF) begin
                        state_d = CLEAR;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end

                // Moving past the bottom row scrolls instead of leaving the screen.
                if (newline) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
                        state_d = SCROLL;
                        idx_d   = '0;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end

            CLEAR, SCROLL: begin
                we    = 1'b1;
                waddr = idx_q;
                if (state_q == SCROLL && idx_q < SCROLL_COPY_END) begin
                    wdata = mem_q[idx_q + ROW_STRIDE];
                end else begin
                    wdata = SPACE;
                end
                if (idx_q == LAST_CELL) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end

            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign inRange  = (rin < 4'(ROWS)) && (cin < 6'(COLS));
    assign readIdx  = inRange ? cell_index(rin, cin) : '0;
    assign charout  = inRange ? mem_q[readIdx] : SPACE;

    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign cur_row  = row_q;
    assign cur_col  = col_q;

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench: a behavioural screen model queues expected cells and cursor
// positions as characters are sent, and the queue is drained against the DUT.
module tb_text_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rin;
    logic [5:0] cin;
    logic [7:0] charout;
    logic [3:0] cur_row;
    logic [5:0] cur_col;
    logic       busy;

    text_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rin      (rin),
        .cin      (cin),
        .charout  (charout),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         isCursor;
        logic [3:0] r;
        logic [5:0] c;
        logic [7:0] exp;
    } expItem;

    expItem     sb[$];
    logic [7:0] mMem [140];
    int         mRow;
    int         mCol;
    int         checks = 0;
    int         errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mScroll();
        for (int i = 0; i < 120; i++) mMem[i] = mMem[i + 20];
        for (int i = 120; i < 140; i++) mMem[i] = 8'h20;
    endtask

    task automatic mClear();
        for (int i = 0; i < 140; i++) mMem[i] = 8'h20;
        mRow = 0;
        mCol = 0;
    endtask

    task automatic mNewline();
        mCol = 0;
        if (mRow == 6) mScroll();
        else mRow++;
    endtask

    task automatic modelApply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            mMem[mRow * 20 + mCol] = c;
            if (mCol == 19) mNewline();
            else mCol++;
        end else if (c == 8'h0A || c == 8'h0D) begin
            mNewline();
        end else if (c == 8'h08) begin
            if (mRow != 0 || mCol != 0) begin
                if (mCol == 0) begin
                    mCol = 19;
                    mRow--;
                end else begin
                    mCol--;
                end
                mMem[mRow * 20 + mCol] = 8'h20;
            end
        end else if (c == 8'h0C) begin
            mClear();
        end
    endtask

    task automatic pushCell(input int r, input int c);
        expItem e;
        e.tag      = $sformatf("cell_%0d_%0d", r, c);
        e.isCursor = 1'b0;
        e.r        = 4'(r);
        e.c        = 6'(c);
        e.exp      = (r < 7 && c < 20) ? mMem[r * 20 + c] : 8'h20;
        sb.push_back(e);
    endtask

    task automatic pushAllCells();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++) pushCell(r, c);
    endtask

    task automatic pushCursor(input string tag);
        expItem e;
        e.tag      = tag;
        e.isCursor = 1'b1;
        e.r        = 4'(mRow);
        e.c        = 6'(mCol);
        e.exp      = 8'h00;
        sb.push_back(e);
    endtask

    task automatic drainQueue();
        expItem e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.isCursor) begin
                #1;
                checkOutput(e.tag, {22'b0, cur_row, cur_col}, {22'b0, e.r, e.c});
            end else begin
                rin = e.r;
                cin = e.c;
                #1;
                checkOutput(e.tag, {24'b0, charout}, {24'b0, e.exp});
            end
        end
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = c;
        modelApply(c);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        int cnt;
        logic [7:0] code;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rin      = '0;
        cin      = '0;
        mClear();

        #1;
        checkOutput("reset_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd1);
        checkOutput("reset_cursor", {22'b0, cur_row, cur_col}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        waitIdle(cnt);
        checkOutput("reset_clear_cycles", cnt, 32'd140);
        pushAllCells();
        pushCell(7, 0);
        pushCell(0, 20);
        pushCell(15, 63);
        pushCursor("cursor_after_reset");
        drainQueue();

        applyStimulus(8'h41);
        applyStimulus(8'h42);
        pushCell(0, 0);
        pushCell(0, 1);
        pushCursor("cursor_AB");
        drainQueue();

        applyStimulus(8'h0C);
        waitIdle(cnt);
        checkOutput("ff_clear_cycles", cnt, 32'd140);
        pushCell(0, 0);
        pushCursor("cursor_after_ff");
        drainQueue();

        for (int i = 0; i < 20; i++) applyStimulus(8'h58);
        pushCursor("cursor_row_wrap");
        drainQueue();
        applyStimulus(8'h08);
        pushCell(0, 19);
        pushCell(0, 18);
        pushCursor("cursor_bs_wrap");
        drainQueue();

        applyStimulus(8'h0C);
        waitIdle(cnt);
        applyStimulus(8'h08);
        pushCursor("cursor_bs_origin");
        drainQueue();

        // Stop one short of the last cell so the line feed triggers the scroll.
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                if (!(r == 6 && c == 19)) applyStimulus(8'h30 + 8'(r));
        pushCursor("cursor_before_lf");
        drainQueue();
        applyStimulus(8'h0A);
        waitIdle(cnt);
        checkOutput("lf_scroll_cycles", cnt, 32'd140);
        pushAllCells();
        pushCursor("cursor_after_lf_scroll");
        drainQueue();

        for (int c = 0; c < 19; c++) applyStimulus(8'h61);
        applyStimulus(8'h62);
        in_valid = 1'b1;
        in_data  = 8'h41;
        cnt = 0;
        while (!in_ready && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("wrap_scroll_cycles", cnt, 32'd140);
        modelApply(8'h41);
        @(negedge clk);
        in_valid = 1'b0;
        pushAllCells();
        pushCursor("cursor_held_valid");
        drainQueue();

        applyStimulus(8'h0C);
        repeat (70) @(negedge clk);
        checkOutput("busy_mid_clear", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        mClear();
        #1;
        checkOutput("midsweep_reset_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("midsweep_reset_cursor", {22'b0, cur_row, cur_col}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitIdle(cnt);
        checkOutput("midsweep_restart_cycles", cnt, 32'd140);
        pushAllCells();
        drainQueue();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: code = 8'h61 + 8'($urandom_range(0, 25));
                6:       code = 8'h08;
                7:       code = 8'h0D;
                8:       code = 8'h01;
                default: code = 8'h7F;
            endcase
            applyStimulus(code);
        end
        waitIdle(cnt);
        checkOutput("idle_after_random", {31'b0, in_ready}, 32'd1);
        pushAllCells();
        pushCursor("cursor_random");
        drainQueue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 in_data  in  8  character or control code to apply at the cursor.
REQ-004 in_valid  in  1  in_data is valid this cycle.
REQ-005 in_ready  out  1  buffer accepts in_data this cycle.
REQ-006 rin  in  4  display row queried by the pixel stage.
REQ-007 cin  in  6  display column queried by the pixel stage.
REQ-008 charout  out  8  character id stored at (rin, cin).
REQ-009 cur_row  out  4  cursor row, 0..6.
REQ-010 cur_col  out  6  cursor column, 0..19.
REQ-011 busy  out  1  clear or scroll sweep in progress; equals ~in_ready.

Function
REQ-012 Storage SHALL be 7 rows x 20 columns of 8-bit ids; cell index = row*20 + col, range 0..139.
REQ-013 charout SHALL be combinational from (rin, cin): stored id when rin<7 and cin<20, else 8'h20 (space).
REQ-014 A transfer SHALL occur only when in_valid and in_ready are both high at a rising edge; in_data is ignored otherwise.
REQ-015 States SHALL be IDLE, CLEAR and SCROLL; in_ready SHALL be 1 only in IDLE.
REQ-016 Printable code 8'h20..8'h7E SHALL be written at the cursor on the accepting edge, and the cursor SHALL advance one column.
REQ-017 Advance from col 19 SHALL wrap to col 0 of the next row.
REQ-018 Advance from (6,19) SHALL enter SCROLL and leave the cursor at (6,0).
REQ-019 Code 8'h0A or 8'h0D SHALL move the cursor to col 0 of the next row; on row 6 it SHALL enter SCROLL with the cursor at (6,0).
REQ-020 Code 8'h08 (backspace) SHALL move the cursor back one cell and write 8'h20 there.
REQ-021 Backspace SHALL wrap from col 0 to col 19 of the previous row, and SHALL be a no-op at (0,0).
REQ-022 Code 8'h0C SHALL enter CLEAR and set the cursor to (0,0).
REQ-023 Any other code SHALL be accepted and discarded, with no change to state.
REQ-024 SCROLL SHALL use sweep index i = 0..139, one cell per cycle: i<120 copies cell i+20 into cell i; i>=120 writes 8'h20.
REQ-025 SCROLL SHALL return to IDLE on the edge that processes i=139, giving exactly 140 cycles with in_ready low.
REQ-026 CLEAR SHALL write 8'h20 to cell i for i = 0..139, one cell per cycle (140 cycles), then return to IDLE.
REQ-027 charout during a sweep MAY show partially updated content; no read stall SHALL be applied.
REQ-028 cur_row and cur_col SHALL be registered and SHALL reflect the transfer on the edge after acceptance.

Reset
REQ-029 Reset assertion SHALL asynchronously force: state CLEAR, sweep index 0, cursor (0,0), in_ready 0, busy 1.
REQ-030 After reset release the CLEAR sweep SHALL complete 140 cycles before in_ready rises, so cell contents are defined.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep and restart CLEAR from index 0.

Structure
REQ-032 Shared package text_pkg SHALL hold: ROWS=7, COLS=20, CELLS=140, CHAR_W=8, SPACE=8'h20, codes LF/CR/BS/FF, and the state enum.
REQ-033 The block SHALL be a single module with no sub-module; storage SHALL be a flip-flop array so the read port stays combinational.

Verification
REQ-034 Reset, then count cycles: in_ready stays low 140 cycles, then rises; every (r,c) in range reads 8'h20; (7,0) and (0,20) read 8'h20.
REQ-035 Send "AB": charout(0,0)=8'h41, charout(0,1)=8'h42, cursor=(0,2).
REQ-036 Send 20 x 8'h58 from (0,0): cursor=(1,0); then send 8'h08: cursor=(0,19) and cell (0,19)=8'h20.
REQ-037 Fill row r with id 8'h30+r for r=0..6, then send 8'h0A at row 6: in_ready low exactly 140 cycles; afterwards row r holds 8'h31+r for r=0..5, row 6 holds 8'h20, cursor=(6,0).
REQ-038 Hold in_valid high with 8'h41 during a scroll: no write occurs until in_ready=1; the first accepted write lands at (6,0).
REQ-039 Send 8'h0C after content is written: buffer clears over 140 cycles and cursor=(0,0); assert reset at sweep index 70: CLEAR restarts, in_ready rises 140 cycles after reset release.
